// File: rtl/asca16_pkg.sv
// Shared ASCA16 definitions used by the fetch, decode and branch-control blocks.
//   WORD_W / ADDR_W : opcode and address widths
//   ifetch_state_t  : fetch FSM state
//   ifq_entry_t     : prefetch queue entry, opcode tagged with its fetch address
package asca16_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned ADDR_W = 16;

  typedef enum logic [0:0] {
    IDLE,
    RUN
  } ifetch_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [WORD_W-1:0] op;
  } ifq_entry_t;

endpackage

// File: rtl/asca16_ifetch_if.sv
// Fetch-stage bus bundle.
//   fetch_en                    : fetch enable from decode
//   pc_out/rom_rd/rom_data      : synchronous ROM port (data one cycle after rom_rd)
//   br_taken/br_addr            : redirect from branch control
//   op/op_pc/op_valid/op_ready  : opcode handshake to decode
// master = fetch stage, slave = its environment (ROM, decode, branch control).
interface asca16_ifetch_if;
  import asca16_pkg::*;

  logic              fetch_en;
  logic [ADDR_W-1:0] pc_out;
  logic              rom_rd;
  logic [WORD_W-1:0] rom_data;
  logic              br_taken;
  logic [ADDR_W-1:0] br_addr;
  logic [WORD_W-1:0] op;
  logic [ADDR_W-1:0] op_pc;
  logic              op_valid;
  logic              op_ready;

  modport master (
    input  fetch_en, rom_data, br_taken, br_addr, op_ready,
    output pc_out, rom_rd, op, op_pc, op_valid
  );

  modport slave (
    output fetch_en, rom_data, br_taken, br_addr, op_ready,
    input  pc_out, rom_rd, op, op_pc, op_valid
  );

endinterface

// File: rtl/asca16_ifq.sv
// Prefetch queue: synchronous circular FIFO with flush.
//   clk, reset_n          : clock, async active-low reset
//   push, push_data       : write at tail
//   pop                   : drop head (caller guarantees non-empty)
//   flush                 : empty the queue; wins over push and pop
//   head_data             : head entry, straight from storage (registered state only)
//   count                 : number of stored entries
module asca16_ifq #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32,
  localparam int unsigned PW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head_data,
  output logic [PW:0]      count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, rptr_q;
  logic [PW:0]      count_q;

  // Storage is reset so the head reads as zero straight out of reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (push && !flush) begin
      mem_q[wptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop)  rptr_q <= rptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_data = mem_q[rptr_q];
  assign count     = count_q;

endmodule

// File: rtl/asca16_ifetch.sv
// ASCA16 instruction fetch stage.
//   clk, reset_n : core clock, async active-low reset
//   bus          : asca16_ifetch_if.master (ROM port, redirect, opcode handshake)
// Issues one ROM read per cycle while the queue has credit (stored + in-flight < DEPTH),
// tags each returning word with its address and queues it for decode. A redirect flushes
// the queue, drops the word still in flight and reloads the fetch PC.
module asca16_ifetch
  import asca16_pkg::*;
#(
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic             clk,
  input logic             reset_n,
  asca16_ifetch_if.master bus
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  ifetch_state_t     state_q, state_d;
  logic [ADDR_W-1:0] fpc_q, fpc_d;
  logic [ADDR_W-1:0] ipc_q;
  logic              inflight_q;
  logic              rom_rd;
  logic              credit_ok;
  logic [CW-1:0]     count;
  logic              push, pop;
  ifq_entry_t        head, tail;

  // One extra bit so count + inflight cannot wrap.
  assign credit_ok = ({1'b0, count} + (CW+1)'(inflight_q)) < (CW+1)'(DEPTH);

  always_comb begin
    state_d = bus.fetch_en ? RUN : IDLE;
    rom_rd  = (state_q == RUN) && !bus.br_taken && credit_ok;
    fpc_d   = fpc_q;
    if (bus.br_taken) begin
      fpc_d = bus.br_addr;
    end else if (rom_rd) begin
      fpc_d = fpc_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      fpc_q      <= RESET_PC;
      ipc_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fpc_q      <= fpc_d;
      // rom_rd is already low under br_taken, so a redirect also kills the in-flight tag.
      inflight_q <= rom_rd;
      if (rom_rd) ipc_q <= fpc_q;
    end
  end

  assign tail.pc = ipc_q;
  assign tail.op = bus.rom_data;
  assign push    = inflight_q;
  assign pop     = bus.op_valid && bus.op_ready;

  asca16_ifq #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(ifq_entry_t))
  ) u_ifq (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (tail),
    .pop       (pop),
    .flush     (bus.br_taken),
    .head_data (head),
    .count     (count)
  );

  assign bus.pc_out   = fpc_q;
  assign bus.rom_rd   = rom_rd;
  assign bus.op       = head.op;
  assign bus.op_pc    = head.pc;
  assign bus.op_valid = (count != '0);

endmodule

// File: tb/tb_asca16_ifetch.sv
// Bench for asca16_ifetch. Reference model: after reset or any redirect the fetch stage
// must deliver the consecutive addresses target, target+1, ... (mod 2^16) paired with
// their ROM words, in order, with nothing lost, repeated or stale.
module tb_asca16_ifetch;
  import asca16_pkg::*;

  localparam int unsigned DEPTH    = 4;
  localparam logic [15:0] RESET_PC = 16'h0000;

  logic clk = 1'b0;
  logic reset_n;

  asca16_ifetch_if bus ();

  asca16_ifetch #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  always #5 clk = ~clk;

  int errors     = 0;
  int checks     = 0;
  int handshakes = 0;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] op;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] gen_pc;

  function automatic logic [15:0] rom_word(input logic [15:0] a);
    return 16'hA000 + a;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // New expected stream starting at a redirect target.
  task automatic sb_restart(input logic [15:0] a);
    exp_q.delete();
    gen_pc = a;
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back('{pc: gen_pc, op: rom_word(gen_pc)});
      gen_pc = gen_pc + 16'd1;
    end
  endtask

  // Synchronous ROM: word appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (bus.rom_rd) bus.rom_data <= rom_word(bus.pc_out);
  end

  // Monitor: every accepted opcode is compared with the head of the expected stream.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n) begin
      if (bus.op_valid && bus.op_ready) begin
        while (exp_q.size() < 8) begin
          exp_q.push_back('{pc: gen_pc, op: rom_word(gen_pc)});
          gen_pc = gen_pc + 16'd1;
        end
        e = exp_q.pop_front();
        handshakes++;
        chk("stream_op_pc", 32'(bus.op_pc), 32'(e.pc));
        chk("stream_op", 32'(bus.op), 32'(e.op));
      end
      if (bus.br_taken) sb_restart(bus.br_addr);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_pc_out"}, 32'(bus.pc_out), 32'(RESET_PC));
    chk({tag, "_rom_rd"}, 32'(bus.rom_rd), 32'd0);
    chk({tag, "_op_valid"}, 32'(bus.op_valid), 32'd0);
    chk({tag, "_op"}, 32'(bus.op), 32'd0);
    chk({tag, "_op_pc"}, 32'(bus.op_pc), 32'd0);
  endtask

  initial begin
    bus.fetch_en = 1'b0;
    bus.br_taken = 1'b0;
    bus.br_addr  = 16'h0000;
    bus.op_ready = 1'b0;
    reset_n      = 1'b1;
    #1 reset_n   = 1'b0;
    #1 chk_reset_outputs("reset");
    sb_restart(RESET_PC);
    repeat (2) cyc();
    reset_n = 1'b1;

    // Startup: fetch_en sampled at the next edge, opcode valid two edges later.
    bus.fetch_en = 1'b1;
    bus.op_ready = 1'b1;
    cyc();
    chk("start_rom_rd", 32'(bus.rom_rd), 32'd1);
    chk("start_valid_n1", 32'(bus.op_valid), 32'd0);
    cyc();
    chk("start_valid_n2", 32'(bus.op_valid), 32'd0);
    cyc();
    chk("start_valid", 32'(bus.op_valid), 32'd1);
    chk("start_op_pc", 32'(bus.op_pc), 32'(RESET_PC));
    for (int i = 0; i < 10; i++) begin
      chk("stream_rom_rd", 32'(bus.rom_rd), 32'd1);
      chk("stream_valid", 32'(bus.op_valid), 32'd1);
      cyc();
    end

    // Stall: queue fills, reads stop; release must resume without gaps.
    bus.op_ready = 1'b0;
    repeat (8) cyc();
    chk("stall_rom_rd", 32'(bus.rom_rd), 32'd0);
    chk("stall_valid", 32'(bus.op_valid), 32'd1);
    bus.op_ready = 1'b1;
    repeat (8) cyc();

    // Redirect with a partly filled queue and a word in flight.
    bus.op_ready = 1'b0;
    repeat (2) cyc();
    bus.br_taken = 1'b1;
    bus.br_addr  = 16'h0040;
    cyc();
    bus.br_taken = 1'b0;
    chk("br_pc_out", 32'(bus.pc_out), 32'h0040);
    chk("br_flushed", 32'(bus.op_valid), 32'd0);
    cyc();
    chk("br_valid_e1", 32'(bus.op_valid), 32'd0);
    cyc();
    chk("br_valid_e2", 32'(bus.op_valid), 32'd1);
    chk("br_op_pc", 32'(bus.op_pc), 32'h0040);
    chk("br_op", 32'(bus.op), 32'(rom_word(16'h0040)));
    bus.op_ready = 1'b1;
    repeat (4) cyc();

    // Address wrap across 16'hFFFF.
    bus.br_taken = 1'b1;
    bus.br_addr  = 16'hFFFE;
    cyc();
    bus.br_taken = 1'b0;
    repeat (8) cyc();

    // Redirect coinciding with push and pop, then back-to-back redirects.
    bus.br_taken = 1'b1;
    bus.br_addr  = 16'h0123;
    cyc();
    bus.br_taken = 1'b0;
    chk("sim_empty", 32'(bus.op_valid), 32'd0);
    chk("sim_fpc", 32'(bus.pc_out), 32'h0123);
    cyc();
    bus.br_taken = 1'b1;
    bus.br_addr  = 16'h0010;
    cyc();
    bus.br_addr  = 16'h0020;
    cyc();
    bus.br_taken = 1'b0;
    bus.op_ready = 1'b0;
    chk("b2b_fpc", 32'(bus.pc_out), 32'h0020);
    repeat (2) cyc();
    chk("b2b_valid", 32'(bus.op_valid), 32'd1);
    chk("b2b_op_pc", 32'(bus.op_pc), 32'h0020);
    bus.op_ready = 1'b1;
    repeat (4) cyc();

    // Random traffic: decode stalls, fetch enable drops, redirects anywhere.
    for (int i = 0; i < 600; i++) begin
      bus.op_ready = ($urandom_range(0, 3) != 0);
      bus.fetch_en = ($urandom_range(0, 15) != 0);
      bus.br_taken = ($urandom_range(0, 29) == 0);
      bus.br_addr  = 16'($urandom);
      cyc();
    end
    bus.br_taken = 1'b0;
    bus.fetch_en = 1'b1;
    bus.op_ready = 1'b1;
    repeat (6) cyc();

    // Asynchronous reset with a full queue, then restart from RESET_PC.
    bus.op_ready = 1'b0;
    repeat (8) cyc();
    chk("full_rom_rd", 32'(bus.rom_rd), 32'd0);
    chk("full_valid", 32'(bus.op_valid), 32'd1);
    #2 reset_n = 1'b0;
    #1 chk_reset_outputs("async_reset");
    sb_restart(RESET_PC);
    cyc();
    reset_n      = 1'b1;
    bus.op_ready = 1'b1;
    cyc();
    chk("restart_rom_rd", 32'(bus.rom_rd), 32'd1);
    chk("restart_pc_out", 32'(bus.pc_out), 32'(RESET_PC));
    repeat (2) cyc();
    chk("restart_valid", 32'(bus.op_valid), 32'd1);
    chk("restart_op_pc", 32'(bus.op_pc), 32'(RESET_PC));
    repeat (10) cyc();

    chk("handshake_count", 32'(handshakes >= 150), 32'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/asca16_ifetch.md
# asca16_ifetch

Instruction fetch stage of the ASCA16 core, sitting directly upstream of the instruction control/decode block (`instrctl`). It generates the ROM fetch address, absorbs the one-cycle synchronous-ROM latency, and buffers fetched opcodes in a small prefetch queue. Opcodes go to decode with a valid/ready handshake, so decode stalls (`nop_en`) do not lose instructions. Branch redirects from branch control flush the queue and discard in-flight fetches.

## Interface
Parameters:
- `DEPTH`, 4: prefetch queue entries; power of two, ≥ 2.
- `RESET_PC`, 16'h0000: first fetch address after reset.

Ports:
- `clk`, input, 1: core clock; all state updates on the rising edge.
- `reset_n`, input, 1: reset, asynchronous and active-low.
- `fetch_en`, input, 1: fetch enable (driven from `rom_en`).
- `pc_out`, output, 16: ROM fetch address.
- `rom_rd`, output, 1: ROM read strobe. The address is captured at the edge closing the cycle.
- `rom_data`, input, 16: ROM word, valid in the cycle after a `rom_rd` cycle.
- `br_taken`, input, 1: redirect request from branch control.
- `br_addr`, input, 16: redirect target, sampled with `br_taken`.
- `op`, output, 16: head-of-queue opcode.
- `op_pc`, output, 16: address of `op`.
- `op_valid`, output, 1: head entry valid.
- `op_ready`, input, 1: decode accepts `op` (low while decode stalls).

## Operation
- State machine with two states:
  - IDLE: the reset state. Moves to RUN at the first edge where `fetch_en`=1.
  - RUN: moves back to IDLE at any edge where `fetch_en`=0. Queue contents are retained in IDLE. In-flight data still returns and is pushed.
- Fetch PC register `fpc`, drives `pc_out`.
  - `rom_rd = (state==RUN) && !br_taken && (count + inflight < DEPTH)`, combinational.
  - On a `rom_rd` edge: `fpc <= fpc + 1`, modulo 2^16, so 16'hFFFF wraps to 16'h0000.
- `inflight` flag: set on a `rom_rd` edge, cleared otherwise. It tags the returning word with its PC (`ipc`).
- Push: at the edge after a `rom_rd` cycle, `{rom_data, ipc}` is written to the queue tail.
- Pop: at an edge with `op_valid && op_ready`.
  - Push and pop may occur together; `count` is then unchanged.
  - Pop from empty is impossible because `op_valid`=0.
- Flush: at an edge with `br_taken`=1:
  - `count` and the pointers clear.
  - `inflight` is cleared, so the word returning next cycle is dropped.
  - `fpc <= br_addr`.
  - Flush has priority over push, pop and the `fpc` increment.
- Back-to-back `br_taken`: the last one wins.
- `br_taken` in IDLE still loads `fpc` and flushes.
- Queue: circular buffer with `$clog2(DEPTH)`-bit pointers and a `$clog2(DEPTH)+1`-bit `count`. Pointers wrap naturally.
- The credit rule guarantees the queue never overflows.

## Timing
- Reset values:
  - `pc_out`=RESET_PC
  - `rom_rd`=0
  - `op_valid`=0
  - `op`=16'h0000
  - `op_pc`=16'h0000
  - state IDLE, queue empty, `inflight`=0
- Reset asserted mid-operation clears everything immediately. No stale word is pushed after reset release.
- Startup: `fetch_en` is sampled high at edge N. Then `rom_rd`=1 in cycle N, and `op_valid`=1 from edge N+2.
- Redirect penalty: with `br_taken` in cycle E, the target opcode is valid from edge E+2.
- Throughput: with `op_ready` held high in RUN, one opcode per cycle after the 2-cycle fill.
- `op`/`op_pc`/`op_valid` come from queue state only. There is no combinational path from `op_ready` or `rom_data`.

## Structure
- Shared package `asca16_pkg`: `WORD_W`=16, `ADDR_W`=16, and the `ifetch_state_t` enum (IDLE, RUN). These are also used by `instrctl`/`bctl`.
- One sub-module, `asca16_ifq`: a parameterized sync FIFO with push, pop and flush, 32-bit entries `{pc, op}`, and a `count` output. The fetch FSM and PC logic stay in `asca16_ifetch`.

## Test plan
- Reset/start: `fetch_en`=1 from cycle 0 with ROM[i]=16'hA000+i. Required:
  - `op`=A000/A001/A002… with `op_pc`=0/1/2…, one per cycle, from cycle 2.
  - `rom_rd` held high.
- Stall: hold `op_ready`=0 for 8 cycles. Required:
  - `rom_rd` drops once `count+inflight`=4.
  - After release, the output sequence continues with no gap, duplicate or loss.
- Branch: `br_taken`=1 with `br_addr`=16'h0040 while PCs 5–7 are queued and 8 is in flight. Required:
  - 5–8 are discarded.
  - The next `op_pc`=0040, two cycles later.
- Wrap: `br_addr`=16'hFFFE. Required: `op_pc` sequence FFFE, FFFF, 0000, 0001.
- Simultaneous: push, pop and `br_taken` in the same cycle. Required: queue empty and `fpc`=`br_addr`. Then back-to-back `br_taken` to 0x10 then 0x20. Required: first op_pc=0020.
- Async reset mid-stream with the queue full. Required:
  - All outputs reach reset values without a clock edge.
  - After release, fetch restarts at RESET_PC.
